seq_ctrl_unit: RTL and testbench

Parametrised multi-cycle control unit for the calculator datapath. It sequences instructions through the IF/ID/EX/MEM/WB phases and decodes the opcode into registered datapath controls. It handles variable-latency EX operations through a start/done handshake with a watchdog timeout. It also supports an optional MEM-phase skip for non-memory instructions, memory wait states, a halt opcode and a retire strobe. It sits between the instruction register and the datapath register/ALU/stack selects.

---
 rtl/seq_ctrl_unit.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_seq_ctrl_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl_unit.sv
// seq_ctrl_unit: multi-cycle IF/ID/EX/MEM/WB sequencer for the calculator datapath.
// Decodes the opcode into registered class controls and register selects.
// Handles variable-latency EX ops with a start/done handshake and watchdog,
// memory wait states, an optional MEM skip, a retire strobe and a halt state.
module seq_ctrl_unit #(
   parameter int         MEM_SKIP = 1,
   parameter int         TIMEOUT  = 64,
   parameter logic [5:0] MC_OP_A  = 6'd29,
   parameter logic [5:0] MC_OP_B  = 6'd27,
   parameter logic [5:0] HALT_OP  = 6'd63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       ra,
   input  logic [1:0] ra_stack,
   input  logic       imm_zero,
   input  logic       mc_done,
   input  logic       mem_ready,
   output logic [4:0] phase,
   output logic       alu,
   output logic       bra,
   output logic       ld,
   output logic       st,
   output logic       tr,
   output logic       psh,
   output logic       pop,
   output logic       mov,
   output logic       flag_sel,
   output logic [3:0] cond_mask,
   output logic [3:0] reg_sel,
   output logic       mc_start,
   output logic       ex_timeout,
   output logic       retire,
   output logic       halted
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_run;
   logic [CNT_W-1:0] r_exCnt;
   logic             r_exTimeout;

   logic             r_alu;
   logic             r_bra;
   logic             r_ld;
   logic             r_st;
   logic             r_tr;
   logic             r_psh;
   logic             r_pop;
   logic             r_mov;
   logic             r_flagSel;
   logic [3:0]       r_condMask;
   logic [3:0]       r_regSel;
   logic             r_isMc;
   logic             r_isHalt;

   logic             w_decAlu;
   logic             w_decBra;
   logic             w_decLd;
   logic             w_decSt;
   logic             w_decTr;
   logic             w_decPsh;
   logic             w_decPop;
   logic             w_decMov;
   logic             w_decFlagSel;
   logic [3:0]       w_decCond;
   logic [3:0]       w_decRegSel;
   logic             w_decIsMc;
   logic             w_decIsHalt;

   logic [3:0]       w_raSel;
   logic [3:0]       w_stackSel;
   logic             w_forceRa;
   logic             w_isMem;
   logic             w_mcDone;
   logic             w_mcTimeout;
   logic             w_exExit;

   assign w_raSel     = ra ? 4'b0010 : 4'b0001;
   assign w_stackSel  = 4'b0001 << ra_stack;
   assign w_forceRa   = (opcode == 6'd21) || (opcode == 6'd22) || (opcode == 6'd26) ||
                        (opcode == MC_OP_A) || (opcode == MC_OP_B);
   assign w_decIsMc   = (opcode == MC_OP_A) || (opcode == MC_OP_B);
   assign w_decIsHalt = (opcode == HALT_OP);

   assign w_isMem     = r_ld | r_st | r_psh | r_pop;
   assign w_mcDone    = r_isMc && mc_done && (r_exCnt >= CNT_TWO);
   assign w_mcTimeout = r_isMc && (r_exCnt >= CNT_MAX);
   assign w_exExit    = !r_isMc || w_mcDone || w_mcTimeout;

   // Opcode decoder: turns the instruction register into class controls and
   // a one-hot register select. The halt opcode and unmapped opcodes leave
   // every control low.
   always_comb begin
      w_decAlu     = 1'b0;
      w_decBra     = 1'b0;
      w_decLd      = 1'b0;
      w_decSt      = 1'b0;
      w_decTr      = 1'b0;
      w_decPsh     = 1'b0;
      w_decPop     = 1'b0;
      w_decMov     = 1'b0;
      w_decFlagSel = 1'b0;
      w_decCond    = 4'b0000;
      w_decRegSel  = 4'b0000;
      if (opcode != HALT_OP) begin
         if (opcode <= 6'd1) begin
            w_decTr     = 1'b1;
            w_decRegSel = opcode[0] ? 4'b0010 : 4'b0001;
         end else if (opcode == 6'd2) begin
            w_decLd     = 1'b1;
            w_decRegSel = w_raSel;
         end else if (opcode == 6'd3) begin
            w_decSt     = 1'b1;
            w_decRegSel = w_raSel;
         end else if (opcode == 6'd4) begin
            w_decPsh    = 1'b1;
            w_decSt     = 1'b1;
            w_decRegSel = w_stackSel;
         end else if (opcode == 6'd5) begin
            w_decPop    = 1'b1;
            w_decLd     = 1'b1;
            w_decRegSel = w_stackSel;
         end else if (opcode <= 6'd9) begin
            w_decBra = 1'b1;
            case (opcode)
               6'd6:    w_decCond = 4'b0001;
               6'd7:    w_decCond = 4'b0010;
               6'd8:    w_decCond = 4'b0100;
               default: w_decCond = 4'b1000;
            endcase
         end else if (opcode <= 6'd12) begin
            w_decBra = 1'b1;
         end else if (opcode == 6'd20) begin
            w_decAlu     = 1'b1;
            w_decFlagSel = 1'b1;
         end else if (opcode <= 6'd29) begin
            w_decAlu     = 1'b1;
            w_decFlagSel = 1'b1;
            w_decRegSel  = (imm_zero && !w_forceRa) ? 4'b0100 : w_raSel;
         end else if (opcode == 6'd30) begin
            w_decMov    = 1'b1;
            w_decRegSel = w_raSel;
         end
      end
   end

   // Decoded controls are captured on the ID->EX edge and then held through
   // EX/MEM/WB and the following IF/ID until the next instruction is decoded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu      <= 1'b0;
         r_bra      <= 1'b0;
         r_ld       <= 1'b0;
         r_st       <= 1'b0;
         r_tr       <= 1'b0;
         r_psh      <= 1'b0;
         r_pop      <= 1'b0;
         r_mov      <= 1'b0;
         r_flagSel  <= 1'b0;
         r_condMask <= 4'b0000;
         r_regSel   <= 4'b0000;
         r_isMc     <= 1'b0;
         r_isHalt   <= 1'b0;
      end else if (r_state == S_ID) begin
         r_alu      <= w_decAlu;
         r_bra      <= w_decBra;
         r_ld       <= w_decLd;
         r_st       <= w_decSt;
         r_tr       <= w_decTr;
         r_psh      <= w_decPsh;
         r_pop      <= w_decPop;
         r_mov      <= w_decMov;
         r_flagSel  <= w_decFlagSel;
         r_condMask <= w_decCond;
         r_regSel   <= w_decRegSel;
         r_isMc     <= w_decIsMc;
         r_isHalt   <= w_decIsHalt;
      end
   end

   // The first edge after reset release only arms the sequencer, so the
   // first IF cycle starts on that edge rather than ending on it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // EX cycle counter: holds 1 during the first EX cycle and saturates at
   // the watchdog limit so it can never wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exCnt <= '0;
      end else if (r_state == S_ID) begin
         r_exCnt <= CNT_ONE;
      end else if ((r_state == S_EX) && (r_exCnt < CNT_MAX)) begin
         r_exCnt <= r_exCnt + CNT_ONE;
      end
   end

   // Sticky watchdog flag: a done arriving in the same cycle as the limit
   // wins, so only a genuine overrun sets it. Only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exTimeout <= 1'b0;
      end else if ((r_state == S_EX) && w_mcTimeout && !w_mcDone) begin
         r_exTimeout <= 1'b1;
      end
   end

   // Phase state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IF;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-phase logic: EX leaves after one cycle for simple ops, or on
   // done/watchdog for multi-cycle ops; MEM waits on mem_ready only for
   // real memory instructions.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IF: begin
            if (r_run) begin
               w_nextState = S_ID;
            end
         end
         S_ID: begin
            w_nextState = S_EX;
         end
         S_EX: begin
            if (w_exExit) begin
               w_nextState = (w_isMem || (MEM_SKIP == 0)) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (!w_isMem || mem_ready) begin
               w_nextState = S_WB;
            end
         end
         S_WB: begin
            w_nextState = r_isHalt ? S_HALT : S_IF;
         end
         S_HALT: begin
            w_nextState = S_HALT;
         end
         default: begin
            w_nextState = S_IF;
         end
      endcase
   end

   // One-hot phase indicator; every bit is low while halted.
   always_comb begin
      phase = 5'b00000;
      case (r_state)
         S_IF:    phase = 5'b00001;
         S_ID:    phase = 5'b00010;
         S_EX:    phase = 5'b00100;
         S_MEM:   phase = 5'b01000;
         S_WB:    phase = 5'b10000;
         default: phase = 5'b00000;
      endcase
   end

   assign alu        = r_alu;
   assign bra        = r_bra;
   assign ld         = r_ld;
   assign st         = r_st;
   assign tr         = r_tr;
   assign psh        = r_psh;
   assign pop        = r_pop;
   assign mov        = r_mov;
   assign flag_sel   = r_flagSel;
   assign cond_mask  = r_condMask;
   assign reg_sel    = r_regSel;
   assign mc_start   = (r_state == S_EX) && r_isMc && (r_exCnt == CNT_ONE);
   assign ex_timeout = r_exTimeout;
   assign retire     = (r_state == S_WB);
   assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// tb_seq_ctrl_unit: directed bench for seq_ctrl_unit with two instances
// (MEM skip on and off, short watchdog) checked every cycle against a
// phase-level reference model plus hand-computed literal expectations.
module tb_seq_ctrl_unit;

   localparam int         TMO = 8;
   localparam logic [5:0] MCA = 6'd29;
   localparam logic [5:0] MCB = 6'd27;
   localparam logic [5:0] HLT = 6'd63;

   localparam logic [2:0] P_IF   = 3'd0;
   localparam logic [2:0] P_ID   = 3'd1;
   localparam logic [2:0] P_EX   = 3'd2;
   localparam logic [2:0] P_MEM  = 3'd3;
   localparam logic [2:0] P_WB   = 3'd4;
   localparam logic [2:0] P_HALT = 3'd5;

   typedef struct packed {
      logic       alu;
      logic       bra;
      logic       ld;
      logic       st;
      logic       tr;
      logic       psh;
      logic       pop;
      logic       mov;
      logic       fs;
      logic [3:0] cond;
      logic [3:0] rs;
   } ctl_t;

   typedef struct packed {
      logic [2:0] ph;
      logic [7:0] n;
      ctl_t       ctl;
      logic [5:0] op;
      logic       tmo;
   } mst_t;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       ra;
   logic [1:0] raStack;
   logic       immZero;
   logic       mcDone;
   logic       memReady;

   logic [4:0] ph0, ph1;
   logic [3:0] cm0, cm1, rs0, rs1;
   logic       alu0, bra0, ld0, st0, tr0, psh0, pop0, mov0, fs0, mcs0, tmo0, ret0, hlt0;
   logic       alu1, bra1, ld1, st1, tr1, psh1, pop1, mov1, fs1, mcs1, tmo1, ret1, hlt1;
   logic [25:0] act0, act1;

   mst_t m0, m1;
   logic mRun;
   logic chkEn;
   int   vecs;
   int   miscompares;

   seq_ctrl_unit #(.MEM_SKIP(0), .TIMEOUT(TMO)) dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .ra(ra), .ra_stack(raStack),
      .imm_zero(immZero), .mc_done(mcDone), .mem_ready(memReady),
      .phase(ph0), .alu(alu0), .bra(bra0), .ld(ld0), .st(st0), .tr(tr0),
      .psh(psh0), .pop(pop0), .mov(mov0), .flag_sel(fs0), .cond_mask(cm0),
      .reg_sel(rs0), .mc_start(mcs0), .ex_timeout(tmo0), .retire(ret0), .halted(hlt0)
   );

   seq_ctrl_unit #(.MEM_SKIP(1), .TIMEOUT(TMO)) dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .ra(ra), .ra_stack(raStack),
      .imm_zero(immZero), .mc_done(mcDone), .mem_ready(memReady),
      .phase(ph1), .alu(alu1), .bra(bra1), .ld(ld1), .st(st1), .tr(tr1),
      .psh(psh1), .pop(pop1), .mov(mov1), .flag_sel(fs1), .cond_mask(cm1),
      .reg_sel(rs1), .mc_start(mcs1), .ex_timeout(tmo1), .retire(ret1), .halted(hlt1)
   );

   assign act0 = {ph0, alu0, bra0, ld0, st0, tr0, psh0, pop0, mov0, fs0, cm0, rs0,
                  mcs0, tmo0, ret0, hlt0};
   assign act1 = {ph1, alu1, bra1, ld1, st1, tr1, psh1, pop1, mov1, fs1, cm1, rs1,
                  mcs1, tmo1, ret1, hlt1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode table written straight from the opcode map.
   function automatic ctl_t refDecode(input logic [5:0] op, input logic r,
                                      input logic [1:0] stk, input logic iz);
      ctl_t       c = '0;
      logic [3:0] fromRa = r ? 4'b0010 : 4'b0001;
      logic [3:0] fromStk = 4'b0001 << stk;
      if (op == HLT) return c;
      if (op == 6'd0 || op == 6'd1) begin
         c.tr = 1'b1;
         c.rs = (op == 6'd0) ? 4'b0001 : 4'b0010;
      end else if (op == 6'd2) begin
         c.ld = 1'b1; c.rs = fromRa;
      end else if (op == 6'd3) begin
         c.st = 1'b1; c.rs = fromRa;
      end else if (op == 6'd4) begin
         c.psh = 1'b1; c.st = 1'b1; c.rs = fromStk;
      end else if (op == 6'd5) begin
         c.pop = 1'b1; c.ld = 1'b1; c.rs = fromStk;
      end else if (op >= 6'd6 && op <= 6'd9) begin
         c.bra = 1'b1;
         c.cond = 4'b0001 << (op - 6'd6);
      end else if (op >= 6'd10 && op <= 6'd12) begin
         c.bra = 1'b1;
      end else if (op == 6'd20) begin
         c.alu = 1'b1; c.fs = 1'b1;
      end else if (op >= 6'd13 && op <= 6'd29) begin
         c.alu = 1'b1; c.fs = 1'b1;
         if (iz && !(op == 6'd21 || op == 6'd22 || op == 6'd26 || op == MCA || op == MCB))
            c.rs = 4'b0100;
         else
            c.rs = fromRa;
      end else if (op == 6'd30) begin
         c.mov = 1'b1; c.rs = fromRa;
      end
      return c;
   endfunction

   function automatic logic isMcOp(input logic [5:0] op);
      return (op == MCA) || (op == MCB);
   endfunction

   // One instruction-level step: which phase the instruction is in next,
   // given how long it has been in EX and the handshake inputs.
   function automatic mst_t modelNext(input mst_t s, input logic memSkip, input logic run,
                                      input logic [5:0] op, input logic r, input logic [1:0] stk,
                                      input logic iz, input logic done, input logic rdy);
      mst_t t = s;
      logic isMem = s.ctl.ld | s.ctl.st | s.ctl.psh | s.ctl.pop;
      logic leave = 1'b0;
      case (s.ph)
         P_IF: if (run) t.ph = P_ID;
         P_ID: begin
            t.ctl = refDecode(op, r, stk, iz);
            t.op  = op;
            t.n   = 8'd1;
            t.ph  = P_EX;
         end
         P_EX: begin
            if (!isMcOp(s.op)) leave = 1'b1;
            else if (s.n >= 8'd2 && done) leave = 1'b1;
            else if (int'(s.n) == TMO) begin
               leave = 1'b1;
               t.tmo = 1'b1;
            end
            if (leave) t.ph = (isMem || !memSkip) ? P_MEM : P_WB;
            else t.n = s.n + 8'd1;
         end
         P_MEM: if (!isMem || rdy) t.ph = P_WB;
         P_WB: t.ph = (s.op == HLT) ? P_HALT : P_IF;
         default: t.ph = s.ph;
      endcase
      return t;
   endfunction

   function automatic logic [25:0] expOut(input mst_t s);
      logic [4:0] p = (s.ph == P_HALT) ? 5'b00000 : (5'b00001 << s.ph);
      logic mcs = (s.ph == P_EX) && isMcOp(s.op) && (s.n == 8'd1);
      return {p, s.ctl, mcs, s.tmo, s.ph == P_WB, s.ph == P_HALT};
   endfunction

   // Reference model advances on the same edges as the DUTs.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0   <= '0;
         m1   <= '0;
         mRun <= 1'b0;
      end else begin
         m0   <= modelNext(m0, 1'b0, mRun, opcode, ra, raStack, immZero, mcDone, memReady);
         m1   <= modelNext(m1, 1'b1, mRun, opcode, ra, raStack, immZero, mcDone, memReady);
         mRun <= 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Every cycle both instances are compared against the model.
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("model dut0", 32'(act0), 32'(expOut(m0)));
         checkOutput("model dut1", 32'(act1), 32'(expOut(m1)));
      end
   end

   task automatic applyStimulus(input logic [5:0] op, input logic r, input logic [1:0] stk,
                                input logic iz);
      opcode  = op;
      ra      = r;
      raStack = stk;
      immZero = iz;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic doReset(input logic [5:0] op, input logic r, input logic [1:0] stk,
                          input logic iz);
      @(negedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(op, r, stk, iz);
      @(negedge clk);
      chkEn = 1'b1;
      checkOutput("reset state", 32'(act1), 32'({5'b00001, 21'b0}));
      #2;
      rst = 1'b1;
   endtask

   task automatic runDecode(input logic [5:0] op, input logic r, input logic [1:0] stk,
                            input logic iz, input logic [8:0] cls, input logic [3:0] cond,
                            input logic [3:0] rs);
      memReady = 1'b1;
      mcDone   = 1'b0;
      doReset(op, r, stk, iz);
      repeat (4) cyc();
      checkOutput($sformatf("decode op%0d", op),
                  32'({alu1, bra1, ld1, st1, tr1, psh1, pop1, mov1, fs1, cm1, rs1}),
                  32'({cls, cond, rs}));
      repeat (2) cyc();
   endtask

   initial begin
      rst         = 1'b0;
      chkEn       = 1'b0;
      vecs        = 0;
      miscompares = 0;
      mcDone      = 1'b0;
      memReady    = 1'b1;
      applyStimulus(6'd0, 1'b0, 2'd0, 1'b0);

      runDecode(6'd0,  1'b0, 2'd0, 1'b0, 9'b000010000, 4'b0000, 4'b0001);
      runDecode(6'd1,  1'b0, 2'd0, 1'b0, 9'b000010000, 4'b0000, 4'b0010);
      runDecode(6'd2,  1'b0, 2'd0, 1'b0, 9'b001000000, 4'b0000, 4'b0001);
      runDecode(6'd3,  1'b1, 2'd0, 1'b0, 9'b000100000, 4'b0000, 4'b0010);
      runDecode(6'd4,  1'b0, 2'd2, 1'b0, 9'b000101000, 4'b0000, 4'b0100);
      runDecode(6'd5,  1'b1, 2'd3, 1'b0, 9'b001000100, 4'b0000, 4'b1000);
      runDecode(6'd6,  1'b0, 2'd0, 1'b0, 9'b010000000, 4'b0001, 4'b0000);
      runDecode(6'd9,  1'b0, 2'd0, 1'b0, 9'b010000000, 4'b1000, 4'b0000);
      runDecode(6'd11, 1'b0, 2'd0, 1'b0, 9'b010000000, 4'b0000, 4'b0000);
      runDecode(6'd13, 1'b1, 2'd0, 1'b1, 9'b100000001, 4'b0000, 4'b0100);
      runDecode(6'd13, 1'b1, 2'd0, 1'b0, 9'b100000001, 4'b0000, 4'b0010);
      runDecode(6'd20, 1'b1, 2'd0, 1'b1, 9'b100000001, 4'b0000, 4'b0000);
      runDecode(6'd21, 1'b1, 2'd0, 1'b1, 9'b100000001, 4'b0000, 4'b0010);
      runDecode(6'd26, 1'b0, 2'd0, 1'b1, 9'b100000001, 4'b0000, 4'b0001);
      runDecode(6'd30, 1'b1, 2'd0, 1'b0, 9'b000000010, 4'b0000, 4'b0010);
      runDecode(6'd45, 1'b1, 2'd3, 1'b1, 9'b000000000, 4'b0000, 4'b0000);

      memReady = 1'b0;
      doReset(6'd2, 1'b0, 2'd0, 1'b0);
      repeat (5) cyc();
      memReady = 1'b1;
      doReset(6'd0, 1'b0, 2'd0, 1'b0);
      cyc(); checkOutput("t1 c1 phase", 32'(ph1), 32'(5'b00001));
      cyc(); checkOutput("t1 c2 phase", 32'(ph1), 32'(5'b00010));
      cyc(); checkOutput("t1 c3 phase", 32'(ph1), 32'(5'b00100));
      cyc(); checkOutput("t1 c4 wb", 32'({ph1, ret1, tr1, rs1}), 32'({5'b10000, 1'b1, 1'b1, 4'b0001}));
      cyc(); checkOutput("t1 c5 phase", 32'(ph1), 32'(5'b00001));

      memReady = 1'b0;
      doReset(6'd2, 1'b1, 2'd0, 1'b0);
      repeat (3) cyc();
      for (int c = 4; c <= 7; c++) begin
         cyc();
         checkOutput($sformatf("t2 c%0d mem", c), 32'(ph1), 32'(5'b01000));
      end
      memReady = 1'b1;
      cyc(); checkOutput("t2 c8 wb", 32'({ph1, ret1, ld1, rs1}), 32'({5'b10000, 1'b1, 1'b1, 4'b0010}));
      repeat (2) cyc();

      doReset(MCA, 1'b0, 2'd0, 1'b1);
      repeat (3) cyc();
      checkOutput("t3 c3 start", 32'({ph1, mcs1}), 32'({5'b00100, 1'b1}));
      mcDone = 1'b1;
      cyc(); mcDone = 1'b0;
      checkOutput("t3 c4 ex", 32'({ph1, mcs1}), 32'({5'b00100, 1'b0}));
      repeat (3) cyc();
      checkOutput("t3 c7 ex", 32'(ph1), 32'(5'b00100));
      mcDone = 1'b1;
      cyc(); mcDone = 1'b0;
      checkOutput("t3 c8 wb", 32'({ph1, ret1, tmo1, alu1, fs1, rs1}),
                  32'({5'b10000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001}));
      repeat (2) cyc();

      doReset(MCA, 1'b0, 2'd0, 1'b0);
      repeat (10) cyc();
      checkOutput("t4 c10 ex", 32'({ph1, tmo1}), 32'({5'b00100, 1'b0}));
      cyc(); checkOutput("t4 c11 wb", 32'({ph1, ret1, tmo1}), 32'({5'b10000, 1'b1, 1'b1}));
      applyStimulus(6'd0, 1'b0, 2'd0, 1'b0);
      repeat (4) cyc();
      checkOutput("t4 c15 next", 32'({ph1, ret1, tmo1, tr1}), 32'({5'b10000, 1'b1, 1'b1, 1'b1}));
      repeat (2) cyc();
      checkOutput("t4 c17 dut0", 32'({ph0, tmo0}), 32'({5'b10000, 1'b1}));

      doReset(MCB, 1'b1, 2'd0, 1'b1);
      repeat (10) cyc();
      mcDone = 1'b1;
      cyc(); mcDone = 1'b0;
      checkOutput("t4b c11 wb", 32'({ph1, ret1, tmo1, rs1}), 32'({5'b10000, 1'b1, 1'b0, 4'b0010}));
      repeat (2) cyc();

      memReady = 1'b0;
      doReset(6'd7, 1'b0, 2'd0, 1'b0);
      repeat (4) cyc();
      checkOutput("t5 c4 dut0 mem", 32'(ph0), 32'(5'b01000));
      checkOutput("t5 c4 dut1 wb", 32'(ph1), 32'(5'b10000));
      cyc(); checkOutput("t5 c5 dut0 wb", 32'({ph0, ret0, bra0, cm0}), 32'({5'b10000, 1'b1, 1'b1, 4'b0010}));
      cyc();
      memReady = 1'b1;

      doReset(HLT, 1'b0, 2'd0, 1'b0);
      repeat (4) cyc();
      checkOutput("t6 c4 retire", 32'({ph1, ret1}), 32'({5'b10000, 1'b1}));
      for (int c = 5; c < 25; c++) begin
         cyc();
         checkOutput($sformatf("t6 c%0d halt", c), 32'({ph1, hlt1}), 32'({5'b00000, 1'b1}));
      end
      doReset(6'd0, 1'b0, 2'd0, 1'b0);
      cyc(); checkOutput("t6 after reset", 32'({ph1, hlt1}), 32'({5'b00001, 1'b0}));
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
